// File: rtl/overflow_rec_rdout.sv
// overflow_rec_rdout
// Pops one overflow record (start LTC, end LTC, channel) at a time from the
// overflow FIFO and holds it stable so firmware can read it coherently as
// 16-bit register words. Each record is popped exactly once.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   ovf_count         live FIFO occupancy from overflow_fifo_ctrl
//   ovf_start_ltc     head-of-FIFO start LTC (show-ahead)
//   ovf_end_ltc       head-of-FIFO end LTC (show-ahead)
//   ovf_chan          head-of-FIFO channel index
//   ovf_rd_req        one-cycle pop strobe to the FIFO
//   load              one-cycle request to fetch the next record
//   clear             one-cycle request to release the held record
//   auto_load         level: fetch whenever idle and FIFO non-empty
//   rd_addr           register word select
//   rd_data           selected register word (combinational from held state)
//   rec_valid         a record is held
//   load_err          sticky misuse flag (load while busy/holding or empty)
//   err_clr           one-cycle clear of load_err
module overflow_rec_rdout #(
  parameter int unsigned P_LTC_WIDTH  = 49,
  parameter int unsigned P_CHAN_WIDTH = 5,
  parameter int unsigned P_CNT_WIDTH  = 16,
  parameter int unsigned P_SETTLE     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [P_CNT_WIDTH-1:0]  ovf_count,
  input  logic [P_LTC_WIDTH-1:0]  ovf_start_ltc,
  input  logic [P_LTC_WIDTH-1:0]  ovf_end_ltc,
  input  logic [P_CHAN_WIDTH-1:0] ovf_chan,
  output logic                    ovf_rd_req,
  input  logic                    load,
  input  logic                    clear,
  input  logic                    auto_load,
  input  logic [3:0]              rd_addr,
  output logic [15:0]             rd_data,
  output logic                    rec_valid,
  output logic                    load_err,
  input  logic                    err_clr
);

  localparam int unsigned SET_W  = $clog2(P_SETTLE + 2);
  localparam int unsigned WORD_W = 16;
  localparam int unsigned EXT_W  = 64;
  localparam int unsigned CHF_W  = WORD_W - 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_POP    = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  typedef struct packed {
    logic [P_LTC_WIDTH-1:0]  start_ltc;
    logic [P_LTC_WIDTH-1:0]  end_ltc;
    logic [P_CHAN_WIDTH-1:0] chan;
  } rec_t;

  logic [1:0]       state, state_nxt;
  rec_t             held, held_nxt;
  logic [SET_W-1:0] settle_cnt, settle_cnt_nxt;
  logic             rd_req_nxt;
  logic             rec_valid_nxt;
  logic             load_err_nxt;
  logic             err_set;

  // State, held record, settle counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      held       <= '0;
      settle_cnt <= '0;
      ovf_rd_req <= 1'b0;
      rec_valid  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      held       <= held_nxt;
      settle_cnt <= settle_cnt_nxt;
      ovf_rd_req <= rd_req_nxt;
      rec_valid  <= rec_valid_nxt;
      load_err   <= load_err_nxt;
    end
  end

  // Next-state, capture and output decode
  always_comb begin
    state_nxt      = state;
    held_nxt       = held;
    settle_cnt_nxt = settle_cnt;
    err_set        = 1'b0;

    case (state)
      S_IDLE: begin
        // Capture the show-ahead head in the same cycle the trigger is seen
        if ((load || auto_load) && (ovf_count != '0)) begin
          held_nxt.start_ltc = ovf_start_ltc;
          held_nxt.end_ltc   = ovf_end_ltc;
          held_nxt.chan      = ovf_chan;
          state_nxt          = S_POP;
        end else if (load) begin
          err_set = 1'b1;
        end
      end

      S_POP: begin
        err_set        = load;
        settle_cnt_nxt = SET_W'(P_SETTLE);
        state_nxt      = (P_SETTLE == 0) ? S_HOLD : S_SETTLE;
      end

      S_SETTLE: begin
        // Leave once the decrement would reach zero: P_SETTLE cycles here
        err_set = load;
        if (settle_cnt > SET_W'(1)) begin
          settle_cnt_nxt = settle_cnt - SET_W'(1);
        end else begin
          settle_cnt_nxt = '0;
          state_nxt      = S_HOLD;
        end
      end

      S_HOLD: begin
        // clear beats a coincident load, which is then silently dropped
        if (clear) begin
          state_nxt = S_IDLE;
        end else if (load) begin
          err_set = 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    rd_req_nxt    = (state_nxt == S_POP);
    rec_valid_nxt = (state_nxt == S_HOLD);
    // New error has priority over err_clr
    load_err_nxt  = err_set | (load_err & ~err_clr);
  end

  logic [EXT_W-1:0] start_ext;
  logic [EXT_W-1:0] end_ext;

  assign start_ext = EXT_W'(held.start_ltc);
  assign end_ext   = EXT_W'(held.end_ltc);

  // Register read mux
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      4'd0:    rd_data = {rec_valid, load_err, CHF_W'(held.chan)};
      4'd1:    rd_data = start_ext[15:0];
      4'd2:    rd_data = start_ext[31:16];
      4'd3:    rd_data = start_ext[47:32];
      4'd4:    rd_data = start_ext[63:48];
      4'd5:    rd_data = end_ext[15:0];
      4'd6:    rd_data = end_ext[31:16];
      4'd7:    rd_data = end_ext[47:32];
      4'd8:    rd_data = end_ext[63:48];
      4'd9:    rd_data = WORD_W'(ovf_count);
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_overflow_rec_rdout.sv
// Testbench for overflow_rec_rdout: a queue-based FIFO environment with a
// lagging count, and a timestamp-based reference model of the readout.
module tb_overflow_rec_rdout;

  localparam int P_SETTLE = 2;

  typedef struct {
    logic [48:0] s;
    logic [48:0] e;
    logic [4:0]  ch;
  } rec_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] ovf_count;
  logic [48:0] ovf_start_ltc;
  logic [48:0] ovf_end_ltc;
  logic [4:0]  ovf_chan;
  logic        ovf_rd_req;
  logic        load;
  logic        clear;
  logic        auto_load;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rec_valid;
  logic        load_err;
  logic        err_clr;

  overflow_rec_rdout #(
    .P_LTC_WIDTH (49),
    .P_CHAN_WIDTH(5),
    .P_CNT_WIDTH (16),
    .P_SETTLE    (P_SETTLE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ovf_count    (ovf_count),
    .ovf_start_ltc(ovf_start_ltc),
    .ovf_end_ltc  (ovf_end_ltc),
    .ovf_chan     (ovf_chan),
    .ovf_rd_req   (ovf_rd_req),
    .load         (load),
    .clear        (clear),
    .auto_load    (auto_load),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rec_valid    (rec_valid),
    .load_err     (load_err),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_pops   = 0;
  int   size_d   = 0;
  rec_t fifo_q[$];
  bit   rnd_push = 0;

  // Reference model: a record is outstanding from its trigger cycle onward;
  // pop strobe one cycle later, valid from trigger+2+P_SETTLE until cleared.
  bit   m_have = 0;
  int   m_tacc = 0;
  bit   m_err  = 0;
  rec_t m_held;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, act, exp);
    end
  endtask

  function automatic bit exp_valid();
    return m_have && (cyc >= m_tacc + 2 + P_SETTLE);
  endfunction

  function automatic bit exp_rdreq();
    return m_have && (cyc == m_tacc + 1);
  endfunction

  function automatic logic [15:0] exp_word(input logic [3:0] a);
    logic [63:0] s;
    logic [63:0] e;
    int          i;
    s = 64'(m_held.s);
    e = 64'(m_held.e);
    i = int'(a);
    if (i == 0)      return {exp_valid(), m_err, 9'b0, m_held.ch};
    else if (i <= 4) return 16'(s >> (16 * (i - 1)));
    else if (i <= 8) return 16'(e >> (16 * (i - 5)));
    else if (i == 9) return ovf_count;
    else             return 16'h0000;
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    r.s  = 49'({$urandom, $urandom});
    r.e  = 49'({$urandom, $urandom});
    r.ch = 5'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    m_have    = 0;
    m_err     = 0;
    m_held.s  = '0;
    m_held.e  = '0;
    m_held.ch = '0;
  endtask

  task automatic model_step(input bit ld, input bit cl, input bit au);
    bit newerr;
    bit err_clr_now;
    err_clr_now = err_clr;
    newerr = 0;
    if (!m_have) begin
      if ((ld || au) && ovf_count != 0) begin
        m_have    = 1;
        m_tacc    = cyc;
        m_held.s  = ovf_start_ltc;
        m_held.e  = ovf_end_ltc;
        m_held.ch = ovf_chan;
      end else if (ld) begin
        newerr = 1;
      end
    end else if (exp_valid()) begin
      if (cl) m_have = 0;
      else if (ld) newerr = 1;
    end else if (ld) begin
      newerr = 1;
    end
    if (newerr) m_err = 1;
    else if (err_clr_now) m_err = 0;
  endtask

  // One clock cycle: drive the FIFO view, check outputs, apply requests.
  task automatic tick(input bit ld, input bit cl, input bit au, input bit ec);
    bit req_seen;
    ovf_count = 16'(size_d);
    size_d    = fifo_q.size();
    if (fifo_q.size() != 0) begin
      ovf_start_ltc = fifo_q[0].s;
      ovf_end_ltc   = fifo_q[0].e;
      ovf_chan      = fifo_q[0].ch;
    end else begin
      ovf_start_ltc = 49'({$urandom, $urandom});
      ovf_end_ltc   = 49'({$urandom, $urandom});
      ovf_chan      = 5'($urandom);
    end
    rd_addr = 4'($urandom_range(0, 15));
    #1;
    req_seen = ovf_rd_req;
    chk("rd_req", 64'(ovf_rd_req), 64'(exp_rdreq()));
    chk("rec_valid", 64'(rec_valid), 64'(exp_valid()));
    chk("load_err", 64'(load_err), 64'(m_err));
    chk("rd_data", 64'(rd_data), 64'(exp_word(rd_addr)));
    load      = ld;
    clear     = cl;
    auto_load = au;
    err_clr   = ec;
    model_step(ld, cl, au);
    @(negedge clk);
    load    = 1'b0;
    clear   = 1'b0;
    err_clr = 1'b0;
    if (req_seen) begin
      n_pops++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    if (rnd_push && fifo_q.size() < 5 && $urandom_range(0, 5) == 0)
      fifo_q.push_back(rand_rec());
    cyc++;
  endtask

  task automatic peek(input string tag, input logic [3:0] a, input logic [15:0] exp);
    rd_addr = a;
    #1;
    chk(tag, 64'(rd_data), 64'(exp));
  endtask

  initial begin
    rec_t r1;
    rec_t r2;
    bit   au_lvl;

    rst_n = 1'b0; load = 1'b0; clear = 1'b0; auto_load = 1'b0; err_clr = 1'b0;
    rd_addr = '0; ovf_count = '0; ovf_start_ltc = '0; ovf_end_ltc = '0; ovf_chan = '0;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_rdreq", 64'(ovf_rd_req), 64'd0);
    chk("rst_valid", 64'(rec_valid), 64'd0);
    chk("rst_err", 64'(load_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // load with an empty FIFO
    tick(1, 0, 0, 0);
    peek("empty_w0", 4'd0, 16'h4000);
    tick(0, 0, 0, 1);
    peek("errclr_w0", 4'd0, 16'h0000);

    // directed record, latency and word layout
    r1.s = 49'h1_2345_6789_ABCD; r1.e = 49'h1_2345_6789_ABD0; r1.ch = 5'd7;
    fifo_q.push_back(r1);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    #1;
    chk("lat_valid", 64'(rec_valid), 64'd1);
    peek("w0", 4'd0, 16'h8007);
    peek("w1", 4'd1, 16'hABCD);
    peek("w2", 4'd2, 16'h6789);
    peek("w3", 4'd3, 16'h2345);
    peek("w4", 4'd4, 16'h0001);
    peek("w5", 4'd5, 16'hABD0);
    peek("w6", 4'd6, 16'h6789);
    peek("w7", 4'd7, 16'h2345);
    peek("w8", 4'd8, 16'h0001);
    chk("single_pop", 64'(n_pops), 64'd1);

    // load while holding, with a different head presented
    r2.s = 49'h0_0000_1111_2222; r2.e = 49'h0_0000_3333_4444; r2.ch = 5'd19;
    fifo_q.push_back(r2);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    peek("hold_w1", 4'd1, 16'hABCD);
    peek("hold_w5", 4'd5, 16'hABD0);
    chk("hold_err", 64'(load_err), 64'd1);
    chk("hold_nopop", 64'(ovf_rd_req), 64'd0);
    tick(0, 1, 0, 0);
    chk("clr_valid", 64'(rec_valid), 64'd0);
    peek("stale_w1", 4'd1, 16'hABCD);

    // load and clear together in HOLD
    tick(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    tick(1, 1, 0, 0);
    chk("lc_valid", 64'(rec_valid), 64'd0);
    chk("lc_err", 64'(load_err), 64'd1);
    tick(0, 0, 0, 0);
    chk("lc_nopop", 64'(ovf_rd_req), 64'd0);
    tick(0, 0, 0, 1);

    // auto_load drains three records, firmware clears each one
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    n_pops = 0;
    for (int i = 0; i < 3; i++) fifo_q.push_back(rand_rec());
    for (int i = 0; i < 40; i++) tick(0, exp_valid(), 1, 0);
    chk("auto_pops", 64'(n_pops), 64'd3);
    chk("auto_drained", 64'(fifo_q.size()), 64'd0);

    // reset asserted in the POP cycle
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    fifo_q.push_back(rand_rec());
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    #1;
    chk("pre_rst_rdreq", 64'(ovf_rd_req), 64'd1);
    chk("pre_rst_err", 64'(load_err), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdreq", 64'(ovf_rd_req), 64'd0);
    chk("mid_rst_valid", 64'(rec_valid), 64'd0);
    chk("mid_rst_err", 64'(load_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    fifo_q.delete();
    size_d    = 0;
    ovf_count = '0;
    peek("post_rst_w0", 4'd0, 16'h0000);
    cyc += 2;

    // randomized traffic
    au_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      rnd_push = ((i / 256) % 4) != 3;
      if ($urandom_range(0, 49) == 0) au_lvl = ~au_lvl;
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0, au_lvl,
           $urandom_range(0, 11) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/overflow_rec_rdout.md
Name: overflow_rec_rdout

Overview:
- Downstream consumer of overflow_fifo_ctrl. Pops one overflow record at a time from the overflow FIFO: start LTC, end LTC, channel index.
- Holds the popped record stable and presents it to the slow-control register bus as 16-bit words.
- Frees firmware from sampling 49-bit LTC buses that change on every pop. Guarantees each record is popped exactly once and read coherently.

Parameters:
- P_LTC_WIDTH, 49, width of the start/end LTC fields (must be 33..64).
- P_CHAN_WIDTH, 5, channel index width.
- P_CNT_WIDTH, 16, overflow_fifo_count width.
- P_SETTLE, 2, cycles waited after a pop before count is trusted again (FIFO count update latency).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ovf_count  in  P_CNT_WIDTH  overflow_fifo_count from overflow_fifo_ctrl
- ovf_start_ltc  in  P_LTC_WIDTH  head-of-FIFO start LTC (show-ahead)
- ovf_end_ltc  in  P_LTC_WIDTH  head-of-FIFO end LTC (show-ahead)
- ovf_chan  in  P_CHAN_WIDTH  head-of-FIFO channel index
- ovf_rd_req  out  1  one-cycle pop strobe to overflow_fifo_ctrl rd_req
- load  in  1  one-cycle request: fetch next record
- clear  in  1  one-cycle request: release held record
- auto_load  in  1  level: fetch automatically whenever idle and FIFO non-empty
- rd_addr  in  4  register word select
- rd_data  out  16  selected register word (combinational from held state)
- rec_valid  out  1  a record is held
- load_err  out  1  sticky: load while busy/holding, or load with empty FIFO
- err_clr  in  1  one-cycle clear of load_err

Behaviour:
- Reset (async, rst_n=0) values: state IDLE; ovf_rd_req=0; rec_valid=0; load_err=0; held start/end LTC=0; held chan=0; settle counter=0.
- FIFO contract: head data is valid while ovf_count>0. An ovf_rd_req pulse pops the head. ovf_count reflects the pop within P_SETTLE cycles.
- States:
  - IDLE: trigger = load OR (auto_load AND ovf_count!=0).
    - Trigger with ovf_count!=0: capture ovf_start_ltc/ovf_end_ltc/ovf_chan this cycle, go to POP.
    - load with ovf_count==0: set load_err, stay IDLE.
  - POP: ovf_rd_req=1 for exactly this one cycle, go to SETTLE. The settle counter loads P_SETTLE.
  - SETTLE: decrement the counter; at 0 go to HOLD. No pop can issue here.
  - HOLD: rec_valid=1.
    - clear: rec_valid drops next cycle, go to IDLE.
    - load with no clear: ignored, sets load_err.
    - load and clear in the same cycle: clear wins, load ignored, no error.
    - auto_load never pops from HOLD.
- rec_valid is 0 in IDLE/POP/SETTLE and 1 only in HOLD.
- load during POP/SETTLE: ignored, sets load_err.
- clear outside HOLD: no effect.
- Latency: trigger in cycle N → ovf_rd_req in N+1 → rec_valid=1 in N+2+P_SETTLE.
- Register map (rd_addr → rd_data). Unused upper bits are 0; LTC bits above P_LTC_WIDTH-1 read 0.
  - 0: {rec_valid, load_err, 9'b0, held_chan}
  - 1..4: held start LTC, words [15:0],[31:16],[47:32],[63:48]
  - 5..8: held end LTC, same order
  - 9: ovf_count (live, truncated/zero-extended to 16)
  - 10..15: 0
- Held fields change only on capture in IDLE. They keep their last values after clear, so stale data is readable but rec_valid=0.
- load_err clears only on err_clr. An err_clr coincident with a new error: the error wins (set priority).
- rst_n asserted mid-POP: ovf_rd_req deasserts immediately (async). Any record already popped is lost; this is accepted.

Test Plan:
- Reset then idle with ovf_count=0, load pulse → no ovf_rd_req; load_err=1; word0=0x4000. err_clr → word0=0x0000.
- ovf_count=1, start=0x1_2345_6789_ABCD, end=0x1_2345_6789_ABD0, chan=7; load at cycle N → ovf_rd_req high only at N+1; rec_valid at N+4 (P_SETTLE=2). Words 1..4 = ABCD,6789,2345,0001; 5..8 = ABD0,6789,2345,0001; word0=0x8007.
- In HOLD change FIFO head inputs and pulse load → held words unchanged, no ovf_rd_req, load_err=1. Then clear → rec_valid=0 next cycle.
- auto_load=1, ovf_count stepping 3→2→1→0 after each pop, firmware clears each hold after reading → exactly 3 ovf_rd_req pulses, 3 distinct records captured in FIFO order, and no pop with ovf_count=0.
- load and clear in the same cycle in HOLD → IDLE, no pop, load_err unchanged.
- rst_n low during POP → ovf_rd_req, rec_valid, and load_err are 0 immediately (before the next clk edge). After release, state is IDLE and word0=0.
